mips_multicycle_ctrl: RTL and testbench

//  Multicycle MIPS control sequencer driving the RegDst, ALUSrc and MemtoReg selects plus all datapath enables.

---
 rtl/mips_ctrl_pkg.sv | 77 +++++++
 rtl/mips_ctrl_wait_timer.sv | 21 ++
 rtl/mips_multicycle_ctrl.sv | 93 +++++++++
 tb/tb_mips_multicycle_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, state encoding, ALU/PC select codes and output decode for the multicycle MIPS controller
package mips_ctrl_pkg;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_ERROR  = 4'd13
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_t;

  // Outputs that depend on the state alone; pc_jump is the unconditional part of pc_write.
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_jump;
    logic       error;
  } moore_t;

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  endfunction

  function automatic moore_t moore_dec(input state_t s);
    moore_t m;
    m = '0;
    case (s)
      S_FETCH:  m.mem_read = 1'b1;
      S_MEMADR,
      S_ADDIEX: m.alu_src = 1'b1;
      S_MEMRD:  begin m.mem_read = 1'b1; m.alu_src = 1'b1; end
      S_MEMWB:  begin m.reg_write = 1'b1; m.mem_to_reg = 1'b1; end
      S_MEMWR:  begin m.mem_write = 1'b1; m.alu_src = 1'b1; end
      S_EXEC:   m.alu_op = ALU_FUNCT;
      S_ALUWB:  begin m.reg_write = 1'b1; m.reg_dst = 1'b1; end
      S_ADDIWB: m.reg_write = 1'b1;
      S_BRANCH: begin m.alu_op = ALU_SUB; m.pc_src = PC_BRANCH; end
      S_JUMP:   begin m.pc_src = PC_JUMP; m.pc_jump = 1'b1; end
      S_ERROR:  m.error = 1'b1;
      default:  m = '0;
    endcase
    return m;
  endfunction
endpackage

// File: rtl/mips_ctrl_wait_timer.sv
// mips_ctrl_wait_timer: counts consecutive memory-wait cycles and flags the cycle that reaches TIMEOUT
//   clock, reset (async active-low), clr (zero the count), inc (one more wait cycle),
//   timeout (this wait cycle is number TIMEOUT; never asserted when TIMEOUT is 0)
module mips_ctrl_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic timeout
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [W-1:0] count;
  always_ff @(posedge clock or negedge reset)
    if (!reset) count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + W'(1);
  // Fires on the wait cycle that would bring the count to TIMEOUT, so exactly TIMEOUT wait cycles are spent.
  assign timeout = (TIMEOUT != 0) && inc && (count == W'(TIMEOUT - 1));
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control sequencer with memory ready handshake and wait timeout
//   in : clock, reset (async active-low), opcode[5:0] (IR[31:26]), zero (ALU flag), mem_ready
//   out: pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, alu_src, mem_to_reg,
//        alu_op[1:0], pc_src[1:0], illegal_op (DECODE pulse), error (sticky timeout), state_out[3:0]
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src,
  output logic       mem_to_reg,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic       error,
  output logic [3:0] state_out
);
  state_t state, next;
  moore_t mo;
  logic waiting, inc, tmo;

  assign waiting = state inside {S_FETCH, S_MEMRD, S_MEMWR};
  assign inc = waiting && !mem_ready;

  mips_ctrl_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (!inc || tmo),
    .inc     (inc),
    .timeout (tmo)
  );

  // tmo only rises when mem_ready is low, so a late ready still advances normally.
  always_comb begin
    next = state;
    case (state)
      S_IDLE:   next = S_FETCH;
      S_FETCH:  next = mem_ready ? S_DECODE : tmo ? S_ERROR : S_FETCH;
      S_DECODE: next = opcode == OP_R ? S_EXEC :
                       (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
                       opcode == OP_BEQ ? S_BRANCH :
                       opcode == OP_ADDI ? S_ADDIEX :
                       opcode == OP_J ? S_JUMP : S_FETCH;
      S_MEMADR: next = opcode == OP_SW ? S_MEMWR : S_MEMRD;
      S_MEMRD:  next = mem_ready ? S_MEMWB : tmo ? S_ERROR : S_MEMRD;
      S_MEMWR:  next = mem_ready ? S_FETCH : tmo ? S_ERROR : S_MEMWR;
      S_EXEC:   next = S_ALUWB;
      S_ADDIEX: next = S_ADDIWB;
      S_MEMWB,
      S_ALUWB,
      S_ADDIWB,
      S_BRANCH,
      S_JUMP:   next = S_FETCH;
      S_ERROR:  next = S_ERROR;
      default:  next = S_IDLE;
    endcase
  end

  // Moore outputs are registered from the next state so they always match the state register.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      mo <= '0;
    end else begin
      state <= next;
      mo <= moore_dec(next);
    end

  assign ir_write   = state == S_FETCH && mem_ready;
  assign pc_write   = ir_write || (state == S_BRANCH && zero) || mo.pc_jump;
  assign mem_read   = mo.mem_read;
  assign mem_write  = mo.mem_write;
  assign reg_write  = mo.reg_write;
  assign reg_dst    = mo.reg_dst;
  assign alu_src    = mo.alu_src;
  assign mem_to_reg = mo.mem_to_reg;
  assign alu_op     = mo.alu_op;
  assign pc_src     = mo.pc_src;
  assign error      = mo.error;
  assign illegal_op = state == S_DECODE && !is_legal(opcode);
  assign state_out  = state;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: randomized scoreboard bench for the multicycle MIPS controller
module tb_mips_multicycle_ctrl;
  localparam int TO = 4;
  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;

  logic clock = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = '0;
  logic pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, alu_src, mem_to_reg;
  logic [1:0] alu_op, pc_src;
  logic illegal_op, error;
  logic [3:0] state_out;

  always #5 clock = ~clock;

  mips_multicycle_ctrl #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .alu_op(alu_op), .pc_src(pc_src), .illegal_op(illegal_op), .error(error),
    .state_out(state_out)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic [13:0] o;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;
  logic [5:0] cur_op = '0;

  function automatic logic [17:0] act();
    return {state_out, pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, alu_src,
            mem_to_reg, alu_op, pc_src, illegal_op, error};
  endfunction

  // Expected cycle: state number plus letters naming the asserted controls.
  // P pc_write, I ir_write, R mem_read, W mem_write, G reg_write, D reg_dst,
  // S alu_src, M mem_to_reg, L illegal_op, E error.
  function automatic exp_t e(input int st, input string f,
                             input logic [1:0] aop = 2'b00, input logic [1:0] psrc = 2'b00);
    logic [13:0] o;
    o = '0;
    for (int i = 0; i < f.len(); i++)
      case (f[i])
        "P": o[13] = 1'b1;
        "I": o[12] = 1'b1;
        "R": o[11] = 1'b1;
        "W": o[10] = 1'b1;
        "G": o[9] = 1'b1;
        "D": o[8] = 1'b1;
        "S": o[7] = 1'b1;
        "M": o[6] = 1'b1;
        "L": o[1] = 1'b1;
        "E": o[0] = 1'b1;
        default: o = o;
      endcase
    o[5:4] = aop;
    o[3:2] = psrc;
    return {4'(st), o};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1));
  endfunction

  always @(negedge clock)
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      checks++;
      if (act() !== x) begin
        errors++;
        $display("FAIL cycle @%0t: state got %0d want %0d, controls got %b want %b",
                 $time, state_out, x.st, act()[13:0], x.o);
      end
    end

  task automatic cyc(input logic mr, input logic z, input exp_t x);
    @(posedge clock);
    #1;
    opcode = cur_op;
    mem_ready = mr;
    zero = z;
    q.push_back(x);
  endtask

  task automatic chk_zero(input string name);
    checks++;
    if (act() !== 18'd0) begin
      errors++;
      $display("FAIL %s: outputs got %h want 0", name, act());
    end
  endtask

  task automatic fetch(input int fw);
    repeat (fw) cyc(1'b0, rb(), e(1, "R"));
    cyc(1'b1, rb(), e(1, "RIP"));
  endtask

  // One instruction: fw memory-wait cycles in FETCH, mw in MEMRD/MEMWR, z on zero during BRANCH.
  task automatic instr(input logic [5:0] op, input int fw, input int mw, input logic z);
    cur_op = op;
    fetch(fw);
    if (!(op inside {R, LW, SW, BEQ, ADDI, J})) begin
      cyc(rb(), rb(), e(2, "L"));
      return;
    end
    cyc(rb(), rb(), e(2, ""));
    if (op == R) begin
      cyc(rb(), rb(), e(7, "", 2'b10));
      cyc(rb(), rb(), e(8, "GD"));
    end else if (op == LW) begin
      cyc(rb(), rb(), e(3, "S"));
      repeat (mw) cyc(1'b0, rb(), e(4, "RS"));
      cyc(1'b1, rb(), e(4, "RS"));
      cyc(rb(), rb(), e(5, "GM"));
    end else if (op == SW) begin
      cyc(rb(), rb(), e(3, "S"));
      repeat (mw) cyc(1'b0, rb(), e(6, "WS"));
      cyc(1'b1, rb(), e(6, "WS"));
    end else if (op == BEQ) begin
      if (z) cyc(rb(), z, e(9, "P", 2'b01, 2'b01));
      else cyc(rb(), z, e(9, "", 2'b01, 2'b01));
    end else if (op == ADDI) begin
      cyc(rb(), rb(), e(10, "S"));
      cyc(rb(), rb(), e(11, "G"));
    end else begin
      cyc(rb(), rb(), e(12, "P", 2'b00, 2'b10));
    end
  endtask

  task automatic release_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    q.push_back(e(0, ""));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [5:0] ops[6];
    logic [5:0] op;
    ops = '{R, LW, SW, BEQ, ADDI, J};
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 chk_zero("reset_state");
    release_reset();
    instr(R, 0, 0, 1'b0);
    instr(LW, 3, 2, 1'b0);
    instr(BEQ, 0, 0, 1'b1);
    instr(BEQ, 0, 0, 1'b0);
    instr(6'b111111, 0, 0, 1'b0);
    instr(SW, 1, 3, 1'b0);
    instr(ADDI, 2, 0, 1'b0);
    instr(J, 0, 0, 1'b1);
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(6) == 6) begin
        do op = 6'($urandom); while (op inside {R, LW, SW, BEQ, ADDI, J});
      end else op = ops[$urandom_range(5)];
      instr(op, int'($urandom_range(TO - 1)), int'($urandom_range(TO - 1)), rb());
    end
    cur_op = SW;
    fetch(0);
    cyc(rb(), rb(), e(2, ""));
    cyc(rb(), rb(), e(3, "S"));
    cyc(1'b0, rb(), e(6, "WS"));
    @(negedge clock);
    #2 reset = 1'b0;
    #1 chk_zero("async_reset_memwr");
    mem_ready = 1'b0;
    @(posedge clock);
    #1 chk_zero("reset_held");
    release_reset();
    instr(ADDI, 0, 0, 1'b0);
    cur_op = SW;
    fetch(0);
    cyc(rb(), rb(), e(2, ""));
    cyc(rb(), rb(), e(3, "S"));
    repeat (TO) cyc(1'b0, rb(), e(6, "WS"));
    repeat (5) cyc(rb(), rb(), e(13, "E"));
    @(negedge clock);
    #2 reset = 1'b0;
    #1 chk_zero("error_cleared_by_reset");
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending %0d want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
